// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way L1 data-cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    FILL      = 3'd4
  } state_t;

  typedef enum logic {
    OP_LD = 1'b0,
    OP_ST = 1'b1
  } op_t;

  // A direct-mapped cache still needs a 1-bit way select port.
  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int tag_bits(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU state: heap-ordered node bits, 0 steers the victim
// search toward the lower half, a touch points every node on the path away.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS    = 4,
  parameter int INDEX_W = 6,
  localparam int WAY_W  = way_bits(WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               touch_en,
  input  logic [INDEX_W-1:0] touch_set,
  input  logic [WAY_W-1:0]   touch_way,
  input  logic [INDEX_W-1:0] victim_set,
  output logic [WAY_W-1:0]   victim
);

  localparam int SETS   = 1 << INDEX_W;
  localparam int LEVELS = $clog2(WAYS);

  if (WAYS == 1) begin : g_no_tree
    logic unused;
    assign unused = ^{clk, reset, touch_en, touch_set, touch_way, victim_set};
    assign victim = '0;
  end else begin : g_tree
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] bits_reg [SETS];
    logic [NODES-1:0] bits_next;
    logic [NODES-1:0] mask;
    logic [NODES-1:0] cur_bits;
    logic [NODES-1:0] shifted;
    logic [WAY_W-1:0] way_shift;
    int               tnode;
    int               vnode;

    // Node n (1-based) covering the touched way at level l is (WAYS+way) >> (LEVELS-l).
    always_comb begin
      bits_next = bits_reg[touch_set];
      mask      = '0;
      way_shift = '0;
      tnode     = 1;
      for (int l = 0; l < LEVELS; l++) begin
        tnode     = (WAYS + int'(touch_way)) >> (LEVELS - l);
        mask      = NODES'(1) << (tnode - 1);
        way_shift = touch_way >> (LEVELS - 1 - l);
        bits_next = way_shift[0] ? (bits_next & ~mask) : (bits_next | mask);
      end
    end

    always_comb begin
      cur_bits = bits_reg[victim_set];
      shifted  = '0;
      vnode    = 1;
      for (int l = 0; l < LEVELS; l++) begin
        shifted = cur_bits >> (vnode - 1);
        vnode   = vnode * 2 + int'(shifted[0]);
      end
      victim = WAY_W'(vnode - WAYS);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int s = 0; s < SETS; s++) bits_reg[s] <= '0;
      end else if (touch_en) begin
        bits_reg[touch_set] <= bits_next;
      end
    end
  end

endmodule

// File: rtl/cache_controller_nway.sv
// N-way set-associative write-back/write-allocate L1D controller sitting
// between the load/store unit and L2, with tree-PLRU victim selection.
module cache_controller_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 5,
  parameter int WAYS     = 4,
  localparam int TAG_W   = tag_bits(ADDR_W, INDEX_W, OFFSET_W),
  localparam int WAY_W   = way_bits(WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld,
  input  logic                  st,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [WAYS*TAG_W-1:0] tag_loaded,
  input  logic [WAYS-1:0]       valid,
  input  logic [WAYS-1:0]       dirty,
  input  logic                  l2_ack,
  output logic [INDEX_W-1:0]    set_idx,
  output logic                  hit,
  output logic                  miss,
  output logic                  load_ready,
  output logic                  write_l1,
  output logic [WAY_W-1:0]      way_sel,
  output logic                  read_l2,
  output logic                  write_l2,
  output logic                  busy,
  output logic [2:0]            state
);

  state_t             state_reg;
  op_t                op_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [INDEX_W-1:0] set_idx_reg;
  logic [WAY_W-1:0]   victim_reg;

  logic [WAYS-1:0]    match;
  logic [WAYS-1:0]    valid_dirty;
  logic               any_hit;
  logic               any_invalid;
  logic               victim_dirty;
  logic               in_compare;
  logic               in_fill;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_W-1:0]   invalid_way;
  logic [WAY_W-1:0]   plru_victim;
  logic [WAY_W-1:0]   victim_next;
  logic               unused;

  // Line offset only selects bytes inside the data array.
  assign unused = ^addr[OFFSET_W-1:0];

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign match[gi] = valid[gi] && (tag_loaded[gi*TAG_W +: TAG_W] == tag_reg);
  end

  // Scanning downward leaves the lowest matching / invalid way selected.
  always_comb begin
    hit_way     = '0;
    invalid_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w])  hit_way     = WAY_W'(w);
      if (!valid[w]) invalid_way = WAY_W'(w);
    end
  end

  assign any_hit      = |match;
  assign any_invalid  = ~&valid;
  assign victim_next  = any_invalid ? invalid_way : plru_victim;
  assign valid_dirty  = valid & dirty;
  assign victim_dirty = valid_dirty[victim_next];

  assign in_compare = (state_reg == COMPARE);
  assign in_fill    = (state_reg == FILL);
  assign hit        = in_compare & any_hit;
  assign miss       = in_compare & ~any_hit;
  assign load_ready = (hit | in_fill) & (op_reg == OP_LD);
  assign write_l1   = (hit & (op_reg == OP_ST)) | in_fill;
  assign read_l2    = (state_reg == ALLOCATE);
  assign write_l2   = (state_reg == WRITEBACK);
  assign busy       = (state_reg != IDLE);
  assign state      = state_reg;
  assign set_idx    = set_idx_reg;

  always_comb begin
    way_sel = '0;
    case (state_reg)
      COMPARE:                   way_sel = any_hit ? hit_way : victim_next;
      WRITEBACK, ALLOCATE, FILL: way_sel = victim_reg;
      default:                   way_sel = '0;
    endcase
  end

  plru_tree #(
    .WAYS    (WAYS),
    .INDEX_W (INDEX_W)
  ) u_plru (
    .clk        (clk),
    .reset      (reset),
    .touch_en   (hit | in_fill),
    .touch_set  (set_idx_reg),
    .touch_way  (in_fill ? victim_reg : hit_way),
    .victim_set (set_idx_reg),
    .victim     (plru_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= OP_LD;
      tag_reg     <= '0;
      set_idx_reg <= '0;
      victim_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld || st) begin
            state_reg   <= COMPARE;
            op_reg      <= st ? OP_ST : OP_LD;
            tag_reg     <= addr[ADDR_W-1 -: TAG_W];
            set_idx_reg <= addr[OFFSET_W +: INDEX_W];
          end
        end
        COMPARE: begin
          if (any_hit) begin
            state_reg <= IDLE;
          end else begin
            victim_reg <= victim_next;
            state_reg  <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (l2_ack) state_reg <= ALLOCATE;
        ALLOCATE:  if (l2_ack) state_reg <= FILL;
        FILL:      state_reg <= IDLE;
        default:   state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench for cache_controller_nway at default parameters (4 ways, 64 sets).
module tb_cache_controller_nway;

  localparam int ADDR_W   = 32;
  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 5;
  localparam int WAYS     = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  ld = 1'b0;
  logic                  st = 1'b0;
  logic                  l2_ack = 1'b0;
  logic [ADDR_W-1:0]     addr = '0;
  logic [WAYS*TAG_W-1:0] tag_loaded = '0;
  logic [WAYS-1:0]       valid = '0;
  logic [WAYS-1:0]       dirty = '0;
  logic [INDEX_W-1:0]    set_idx;
  logic                  hit, miss, load_ready, write_l1, read_l2, write_l2, busy;
  logic [WAY_W-1:0]      way_sel;
  logic [2:0]            state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_controller_nway dut (
    .clk        (clk),
    .reset      (reset),
    .ld         (ld),
    .st         (st),
    .addr       (addr),
    .tag_loaded (tag_loaded),
    .valid      (valid),
    .dirty      (dirty),
    .l2_ack     (l2_ack),
    .set_idx    (set_idx),
    .hit        (hit),
    .miss       (miss),
    .load_ready (load_ready),
    .write_l1   (write_l1),
    .way_sel    (way_sel),
    .read_l2    (read_l2),
    .write_l2   (write_l2),
    .busy       (busy),
    .state      (state)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_addr(input logic [20:0] t, input logic [5:0] s);
    return {t, s, 5'b0};
  endfunction

  task automatic set_tags(input logic [20:0] t0, input logic [20:0] t1,
                          input logic [20:0] t2, input logic [20:0] t3);
    tag_loaded = {t3, t2, t1, t0};
  endtask

  // Presents a request for one edge; returns sitting in COMPARE.
  task automatic request(input logic [31:0] a, input logic l, input logic s);
    addr = a;
    ld   = l;
    st   = s;
    tick();
    ld = 1'b0;
    st = 1'b0;
    $display("txn addr=%08h ld=%0b st=%0b state=%0d hit=%0b miss=%0b way=%0d",
             a, l, s, state, hit, miss, way_sel);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && state != 3'd0; i++) tick();
    check_val(tag, state, 0);
  endtask

  initial begin
    // Reset state
    #12;
    check_val("rst_state", state, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_way_sel", way_sel, 0);
    check_val("rst_set_idx", set_idx, 0);
    check_val("rst_outs", {hit, miss, load_ready, write_l1, read_l2, write_l2}, 0);
    @(negedge clk) reset = 1'b0;
    tick();

    // Read hit on way 2, set 63
    set_tags(21'h0, 21'h0, 21'h1FFFFF, 21'h0);
    valid = 4'b0100;
    dirty = 4'b0000;
    request(32'hFFFF_FFFF, 1'b1, 1'b0);
    check_val("hit_state", state, 1);
    check_val("hit_hit", hit, 1);
    check_val("hit_miss", miss, 0);
    check_val("hit_way", way_sel, 2);
    check_val("hit_load_ready", load_ready, 1);
    check_val("hit_write_l1", write_l1, 0);
    check_val("hit_set_idx", set_idx, 6'h3F);
    tick();
    check_val("hit_back_idle", state, 0);
    check_val("hit_idle_hit", hit, 0);

    // Clean read miss into an empty set, ack held high
    valid  = 4'b0000;
    l2_ack = 1'b1;
    request(mk_addr(21'h0, 6'd2), 1'b1, 1'b0);
    check_val("cm_miss", miss, 1);
    check_val("cm_hit", hit, 0);
    check_val("cm_way", way_sel, 0);
    check_val("cm_set_idx", set_idx, 2);
    tick();
    check_val("cm_alloc_state", state, 3);
    check_val("cm_read_l2", read_l2, 1);
    check_val("cm_write_l2", write_l2, 0);
    tick();
    check_val("cm_fill_state", state, 4);
    check_val("cm_fill_write_l1", write_l1, 1);
    check_val("cm_fill_load_ready", load_ready, 1);
    check_val("cm_fill_read_l2", read_l2, 0);
    tick();
    check_val("cm_idle", state, 0);
    l2_ack = 1'b0;

    // ld&st together on a hit behaves as a store (set 1, way 0)
    set_tags(21'h0, 21'h101, 21'h102, 21'h103);
    valid = 4'hF;
    dirty = 4'hF;
    request(mk_addr(21'h0, 6'd1), 1'b1, 1'b1);
    check_val("ldst_hit", hit, 1);
    check_val("ldst_way", way_sel, 0);
    check_val("ldst_write_l1", write_l1, 1);
    check_val("ldst_load_ready", load_ready, 0);
    tick();

    // Dirty write miss: PLRU of set 1 now points to way 2, ack after 3 waits
    request(mk_addr(21'h1, 6'd1), 1'b0, 1'b1);
    check_val("dm_miss", miss, 1);
    check_val("dm_way", way_sel, 2);
    tick();
    for (int i = 0; i < 4; i++) begin
      check_val("dm_wb_write_l2", write_l2, 1);
      check_val("dm_wb_read_l2", read_l2, 0);
      check_val("dm_wb_way", way_sel, 2);
      l2_ack = (i == 3);
      tick();
    end
    l2_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_val("dm_al_state", state, 3);
      check_val("dm_al_read_l2", read_l2, 1);
      check_val("dm_al_write_l2", write_l2, 0);
      check_val("dm_al_way", way_sel, 2);
      check_val("dm_al_set_idx", set_idx, 1);
      if (i == 0) begin
        // Request raised mid-ALLOCATE must not disturb the access in flight
        ld   = 1'b1;
        addr = mk_addr(21'h0, 6'h3E);
      end
      l2_ack = (i == 3);
      tick();
    end
    l2_ack = 1'b0;
    check_val("dm_fill_state", state, 4);
    check_val("dm_fill_write_l1", write_l1, 1);
    check_val("dm_fill_load_ready", load_ready, 0);
    check_val("dm_fill_way", way_sel, 2);
    check_val("dm_fill_set_idx", set_idx, 1);
    tick();
    check_val("b2b_idle", state, 0);
    check_val("b2b_idle_busy", busy, 0);
    tick();
    ld = 1'b0;
    check_val("b2b_compare", state, 1);
    check_val("b2b_set_idx", set_idx, 6'h3E);
    check_val("b2b_hit", hit, 1);
    check_val("b2b_load_ready", load_ready, 1);
    tick();

    // PLRU sequence on set 0, all ways valid and clean
    set_tags(21'h10, 21'h11, 21'h12, 21'h13);
    valid  = 4'hF;
    dirty  = 4'h0;
    l2_ack = 1'b1;
    for (int w = 0; w < 4; w++) begin
      request(mk_addr(21'(16 + w), 6'd0), 1'b1, 1'b0);
      check_val("plru_hit", hit, 1);
      check_val("plru_hit_way", way_sel, w);
      tick();
    end
    request(mk_addr(21'h55, 6'd0), 1'b1, 1'b0);
    check_val("plru_miss1", miss, 1);
    check_val("plru_victim1", way_sel, 0);
    wait_idle("plru_miss1_done");
    request(mk_addr(21'h10, 6'd0), 1'b1, 1'b0);
    check_val("plru_hit_w0", way_sel, 0);
    tick();
    request(mk_addr(21'h12, 6'd0), 1'b1, 1'b0);
    check_val("plru_hit_w2", way_sel, 2);
    tick();
    request(mk_addr(21'h56, 6'd0), 1'b1, 1'b0);
    check_val("plru_miss2", miss, 1);
    check_val("plru_victim2", way_sel, 1);
    wait_idle("plru_miss2_done");

    // Asynchronous reset mid-ALLOCATE
    l2_ack = 1'b0;
    request(mk_addr(21'h57, 6'd0), 1'b1, 1'b0);
    check_val("ar_victim", way_sel, 3);
    tick();
    check_val("ar_read_l2_before", read_l2, 1);
    #2 reset = 1'b1;
    #1;
    check_val("ar_read_l2", read_l2, 0);
    check_val("ar_state", state, 0);
    check_val("ar_busy", busy, 0);
    check_val("ar_way_sel", way_sel, 0);
    check_val("ar_set_idx", set_idx, 0);
    @(negedge clk) reset = 1'b0;
    tick();
    l2_ack = 1'b1;
    request(mk_addr(21'h58, 6'd0), 1'b1, 1'b0);
    check_val("ar_post_miss", miss, 1);
    check_val("ar_post_victim", way_sel, 0);
    wait_idle("ar_post_done");
    l2_ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
